// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL bring-up sequencer.
// The state encoding is visible on state_o, so it must stay fixed.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWR_DN    = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    // Width of the retry counter; never narrower than one bit, even with no retries.
    function automatic int retry_w(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    function automatic bit cnt_fits(input int cnt_w, input int value);
        return (cnt_w >= 31) || (value < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses <= so both flops sample the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_bringup_seq.sv
// PLL power-up, lock qualification and datapath gating sequencer.
// Runs on the reference clock; every output is a flop loaded from the next-state decode.
module pll_bringup_seq
    import pll_seq_pkg::*;
#(
    parameter int EN_LOW_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16,
    localparam int RW           = retry_w(MAX_RETRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          pll_lock_i,
    output logic          pll_en_o,
    output logic          dp_enable_o,
    output logic          clk_ready_o,
    output logic          lol_o,
    output logic          fail_o,
    output logic [RW-1:0] retry_cnt_o,
    output logic [2:0]    state_o
);

    generate
        if (EN_LOW_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 || MAX_RETRIES < 0) begin : g_bad_param
            $fatal(1, "pll_bringup_seq: timing parameter out of range");
        end
        if (!cnt_fits(CNT_W, EN_LOW_CYCLES) || !cnt_fits(CNT_W, LOCK_TIMEOUT) ||
            !cnt_fits(CNT_W, STABLE_CYCLES)) begin : g_bad_cnt_w
            $fatal(1, "pll_bringup_seq: CNT_W too narrow for the cycle counts");
        end
    endgenerate

    localparam logic [CNT_W-1:0] EN_LOW_LAST  = CNT_W'(EN_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic               pll_en_q, pll_en_d;
    logic               run_q, run_d;
    logic               lol_q, lol_d;
    logic               fail_q, fail_d;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            pll_en_q <= 1'b0;
            run_q    <= 1'b0;
            lol_q    <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            pll_en_q <= pll_en_d;
            run_q    <= run_d;
            lol_q    <= lol_d;
            fail_q   <= fail_d;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (start_i) begin
                    state_d = ST_PWR_DN;
                    retry_d = '0;
                end
            end
            ST_PWR_DN: begin
                if (cnt_q == EN_LOW_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_PWR_DN;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s) state_d = ST_PWR_DN;
            end
            default: state_d = ST_IDLE;
        endcase
        // Shutdown wins over everything, including a pending retry increment.
        if (stop_i) begin
            state_d = ST_IDLE;
            retry_d = retry_q;
        end
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        pll_en_d = state_d inside {ST_WAIT_LOCK, ST_STABLE, ST_RUN};
        run_d    = (state_d == ST_RUN);
        fail_d   = (state_d == ST_FAIL);
        lol_d    = (state_q == ST_RUN) && (state_d == ST_PWR_DN);
    end

    assign pll_en_o    = pll_en_q;
    assign dp_enable_o = run_q;
    assign clk_ready_o = run_q;
    assign lol_o       = lol_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pll_bringup_seq.sv
// Self-checking bench: directed bring-up scenarios plus a random soak, all
// compared every cycle against a timestamp-based behavioural model.
module tb_pll_bringup_seq;

    localparam int EN_LOW = 4;
    localparam int TMO    = 32;
    localparam int STB    = 8;
    localparam int MAXR   = 2;

    localparam int S_IDLE = 0, S_PWR = 1, S_WAIT = 2, S_STABLE = 3, S_RUN = 4, S_FAIL = 5;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       stop_i;
    logic       pll_lock_i;
    logic       pll_en_o;
    logic       dp_enable_o;
    logic       clk_ready_o;
    logic       lol_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
    logic [2:0] state_o;

    pll_bringup_seq #(
        .EN_LOW_CYCLES (EN_LOW),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .pll_lock_i  (pll_lock_i),
        .pll_en_o    (pll_en_o),
        .dp_enable_o (dp_enable_o),
        .clk_ready_o (clk_ready_o),
        .lol_o       (lol_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase, edge timestamps and a lock-sample history queue.
    int m_ph, m_retry, m_lol, m_edge, m_entry;
    int m_lq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = S_IDLE; m_retry = 0; m_lol = 0; m_edge = 0; m_entry = 0;
        m_lq = '{0, 0};
    endtask

    task automatic model_step();
        int ls, el, nxt, lol;
        ls = m_lq[0];
        void'(m_lq.pop_front());
        m_lq.push_back(int'(pll_lock_i));
        m_edge++;
        el  = m_edge - m_entry;
        nxt = m_ph;
        lol = 0;
        if (stop_i) begin
            nxt = S_IDLE;
        end else begin
            case (m_ph)
                S_IDLE, S_FAIL: if (start_i) begin nxt = S_PWR; m_retry = 0; end
                S_PWR:          if (el >= EN_LOW) nxt = S_WAIT;
                S_WAIT: begin
                    if (ls != 0) nxt = S_STABLE;
                    else if (el >= TMO) begin
                        if (m_retry < MAXR) begin m_retry++; nxt = S_PWR; end
                        else nxt = S_FAIL;
                    end
                end
                S_STABLE: begin
                    if (ls == 0) nxt = S_WAIT;
                    else if (el >= STB) begin nxt = S_RUN; m_retry = 0; end
                end
                S_RUN: if (ls == 0) begin nxt = S_PWR; lol = 1; end
                default: nxt = S_IDLE;
            endcase
        end
        if (nxt != m_ph) m_entry = m_edge;
        m_ph  = nxt;
        m_lol = lol;
    endtask

    task automatic compare_all();
        check("state",     state_o,     m_ph);
        check("pll_en",    pll_en_o,    (m_ph == S_WAIT || m_ph == S_STABLE || m_ph == S_RUN));
        check("dp_enable", dp_enable_o, (m_ph == S_RUN));
        check("clk_ready", clk_ready_o, (m_ph == S_RUN));
        check("fail",      fail_o,      (m_ph == S_FAIL));
        check("lol",       lol_o,       m_lol);
        check("retry",     retry_cnt_o, m_retry);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input int s, input int budget, input string tag, output int n);
        n = 0;
        while (state_o != 3'(s) && n < budget) begin
            tick();
            n++;
        end
        check(tag, state_o, s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, en_hi;
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; pll_lock_i = 1'b0;
        model_reset();
        run(3);
        rst_n = 1'b1;
        run(2);

        // Normal bring-up
        start_i = 1'b1; tick(); start_i = 1'b0;
        run(10);
        pll_lock_i = 1'b1;
        wait_state(S_STABLE, 20, "reach_stable", n);
        check("stable_latency", n, 3);
        wait_state(S_RUN, 20, "reach_run", n);
        check("run_latency", n, STB);

        // Loss of lock in RUN, then automatic relock
        run($urandom_range(2, 10));
        pll_lock_i = 1'b0;
        n = 0;
        while (dp_enable_o && n < 10) begin tick(); n++; end
        check("dp_cutoff", n, 3);
        run($urandom_range(0, 5));
        pll_lock_i = 1'b1;
        wait_state(S_STABLE, 60, "relock_stable", n);

        // Glitch during STABLE cycle 5
        run(4);
        pll_lock_i = 1'b0; tick(); pll_lock_i = 1'b1;
        wait_state(S_RUN, 40, "glitch_run", n);
        check("glitch_relock", n, 11);

        // Lock never arrives: three attempts, then FAIL
        pll_lock_i = 1'b0;
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        tick();
        start_i = 1'b1; tick(); start_i = 1'b0;
        n = 0; en_hi = 0;
        while (state_o != 3'(S_FAIL) && n < 300) begin
            tick(); n++;
            if (pll_en_o) en_hi++;
        end
        check("reach_fail", state_o, S_FAIL);
        check("en_high_total", en_hi, 3 * TMO);
        check("fail_retry", retry_cnt_o, MAXR);
        run(3);
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("restart_state", state_o, S_PWR);
        check("restart_retry", retry_cnt_o, 0);

        // start and stop together in RUN; stop during PWR_DN
        pll_lock_i = 1'b1;
        wait_state(S_RUN, 100, "run_before_stop", n);
        start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
        check("stop_in_run", state_o, S_IDLE);
        check("stop_no_lol", lol_o, 0);
        start_i = 1'b1; tick(); start_i = 1'b0;
        run($urandom_range(0, 2));
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check("stop_in_pwr", state_o, S_IDLE);
        run(3);

        // Asynchronous reset mid-WAIT_LOCK
        pll_lock_i = 1'b0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        wait_state(S_WAIT, 20, "reach_wait", n);
        run($urandom_range(1, 10));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_pll_en", pll_en_o, 0);
        check("async_state", state_o, S_IDLE);
        check("async_retry", retry_cnt_o, 0);
        pll_lock_i = 1'b1;
        run(3);
        rst_n = 1'b1;
        start_i = 1'b1; tick(); start_i = 1'b0;
        wait_state(S_RUN, 40, "post_reset_run", n);
        check("post_reset_latency", n + 1, 1 + EN_LOW + 1 + STB);

        // Random soak
        for (int i = 0; i < 1500; i++) begin
            start_i = ($urandom_range(0, 19) == 0);
            stop_i  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) pll_lock_i = ~pll_lock_i;
            tick();
        end
        start_i = 1'b0; stop_i = 1'b0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
